// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the MAC array tile sequencer.
// mac_seq_state_t : sequencer state encoding
// MAC_SEQ_CNT_W   : default width of the pixel count / active index
package mac_seq_pkg;

   localparam int MAC_SEQ_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WLOAD  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } mac_seq_state_t;

endpackage

// File: rtl/mac_sequencer.sv
// Purpose : sequences one MAC-array tile (weight load, pixel stream, accumulator drain).
// Latency : first accum_out enq OUT_LAT cycles after first ifmap enq; done pulses the cycle after the last drain beat.
// Backpr. : src_valid=0 in an active state freezes state and k and zeroes en and every enq.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, npix         tile request and pixel count, sampled only in IDLE
//   src_valid           upstream data available (low = stall)
//   busy, done          status: not IDLE / one-cycle completion pulse
//   en, en_weight00, weight_fifo_enq, ifmap_fifo_enq,
//   accum_in_fifo_enq, accum_out_fifo_enq   MAC array controls
//   stall_cnt           stalled active cycles of the current tile (only with MAC_SEQ_PERF_EN)
//
// Optional feature macro: MAC_SEQ_PERF_EN (adds stall_cnt).
module mac_sequencer
   import mac_seq_pkg::*;
#(
   parameter int IC0     = 2,
   parameter int OC0     = 2,
   parameter int OUT_LAT = 2,
   parameter int CNT_W   = MAC_SEQ_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] npix,
   input  logic             src_valid,
   output logic             busy,
   output logic             done,
   output logic             en,
   output logic             en_weight00,
   output logic             weight_fifo_enq,
   output logic             ifmap_fifo_enq,
   output logic             accum_in_fifo_enq,
   output logic             accum_out_fifo_enq
`ifdef MAC_SEQ_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   // k runs one bit wider than npix so npix+OUT_LAT never wraps.
   localparam logic [CNT_W:0] K_ONE     = (CNT_W+1)'(1);
   localparam logic [CNT_W:0] K_WGT_END = (CNT_W+1)'(IC0);
   localparam logic [CNT_W:0] K_LAT     = (CNT_W+1)'(OUT_LAT);
   localparam logic [CNT_W:0] K_OUT_BEG = (CNT_W+1)'(OUT_LAT + 1);

   mac_seq_state_t   state_q, state_d;
   logic [CNT_W:0]   k_q, k_d;
   logic [CNT_W-1:0] npix_q, npix_d;

   logic [CNT_W:0]   npix_ext;
   logic [CNT_W:0]   end_k;
   logic             active;
   logic             go;

   assign npix_ext = {1'b0, npix_q};
   assign end_k    = npix_ext + K_LAT;
   assign active   = (state_q == WLOAD) || (state_q == STREAM) || (state_q == DRAIN);
   assign go       = active && src_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         npix_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         npix_q  <= npix_d;
      end
   end

   // Next state: k advances only on non-stalled active cycles.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      npix_d  = npix_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               npix_d = npix;
               k_d    = '0;
               state_d = (npix != '0) ? WLOAD : DONE;
            end
         end
         WLOAD: begin
            if (src_valid) begin
               k_d     = k_q + K_ONE;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (src_valid) begin
               k_d = k_q + K_ONE;
               if (k_q == npix_ext) begin
                  // With no output latency there is nothing left to drain.
                  state_d = (OUT_LAT == 0) ? DONE : DRAIN;
               end
            end
         end
         DRAIN: begin
            if (src_valid) begin
               k_d = k_q + K_ONE;
               if (k_q == end_k) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore outputs from state and k; src_valid is the only gating input.
   always_comb begin
      busy               = 1'b0;
      done               = 1'b0;
      en                 = 1'b0;
      en_weight00        = 1'b0;
      weight_fifo_enq    = 1'b0;
      ifmap_fifo_enq     = 1'b0;
      accum_in_fifo_enq  = 1'b0;
      accum_out_fifo_enq = 1'b0;

      busy = (state_q != IDLE);
      done = (state_q == DONE);
      if (go) begin
         en                 = 1'b1;
         en_weight00        = (k_q == '0);
         weight_fifo_enq    = (k_q < K_WGT_END);
         ifmap_fifo_enq     = (k_q != '0) && (k_q <= npix_ext);
         accum_in_fifo_enq  = (k_q != '0) && (k_q <= npix_ext);
         accum_out_fifo_enq = (k_q >= K_OUT_BEG) && (k_q <= end_k);
      end
   end

`ifdef MAC_SEQ_PERF_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == IDLE) && start) begin
         stall_d = '0;
      end else if (active && !src_valid && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

   // Array geometry sanity and output consistency.
   a_geom: assert property (@(posedge clk) disable iff (!rst_n) (IC0 >= 1) && (OC0 >= 1));
   a_w00:  assert property (@(posedge clk) disable iff (!rst_n) en_weight00 |-> (weight_fifo_enq && en));
   a_idle: assert property (@(posedge clk) disable iff (!rst_n) !busy |-> !en);

endmodule

// File: tb/tb_mac_sequencer.sv
`timescale 1ns/1ps
module tb_mac_sequencer;

   localparam int IC0     = 2;
   localparam int OC0     = 2;
   localparam int OUT_LAT = 2;
   localparam int CNT_W   = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] npix = '0;
   logic             src_valid = 1'b0;
   logic busy, done, en, en_weight00, weight_fifo_enq, ifmap_fifo_enq;
   logic accum_in_fifo_enq, accum_out_fifo_enq;
`ifdef MAC_SEQ_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
`endif

   // Narrow-counter instance for the npix = 2^CNT_W - 1 boundary.
   logic       w_start = 1'b0;
   logic [3:0] w_npix = '0;
   logic       w_sv = 1'b0;
   logic w_busy, w_done, w_en, w_ew, w_wq, w_iq, w_aiq, w_aoq;
`ifdef MAC_SEQ_PERF_EN
   logic [3:0] w_stall_cnt;
`endif

   always #5 clk = ~clk;

   mac_sequencer #(.IC0(IC0), .OC0(OC0), .OUT_LAT(OUT_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .npix(npix), .src_valid(src_valid),
      .busy(busy), .done(done), .en(en), .en_weight00(en_weight00),
      .weight_fifo_enq(weight_fifo_enq), .ifmap_fifo_enq(ifmap_fifo_enq),
      .accum_in_fifo_enq(accum_in_fifo_enq), .accum_out_fifo_enq(accum_out_fifo_enq)
`ifdef MAC_SEQ_PERF_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   mac_sequencer #(.IC0(IC0), .OC0(OC0), .OUT_LAT(OUT_LAT), .CNT_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(w_start), .npix(w_npix), .src_valid(w_sv),
      .busy(w_busy), .done(w_done), .en(w_en), .en_weight00(w_ew),
      .weight_fifo_enq(w_wq), .ifmap_fifo_enq(w_iq),
      .accum_in_fifo_enq(w_aiq), .accum_out_fifo_enq(w_aoq)
`ifdef MAC_SEQ_PERF_EN
      , .stall_cnt(w_stall_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a tile is a list of active slots 0..npix+OUT_LAT, each
   // consumed by one non-stalled cycle; a done cycle follows the last slot.
   bit m_in_tile = 0;
   bit m_done_now = 0;
   int m_slot = 0;
   int m_last = 0;
   int m_npix = 0;
   int m_stall = 0;

   logic [7:0] last_v;
   int         last_stall;

   // Bit order: busy, done, en, en_weight00, weight, ifmap, accum_in, accum_out.
   function automatic logic [7:0] dut_vec();
      return {busy, done, en, en_weight00, weight_fifo_enq, ifmap_fifo_enq,
              accum_in_fifo_enq, accum_out_fifo_enq};
   endfunction

   function automatic logic [7:0] model_vec(bit sv);
      logic [7:0] v;
      v = '0;
      v[7] = m_in_tile || m_done_now;
      v[6] = m_done_now;
      if (m_in_tile && sv) begin
         v[5] = 1'b1;
         v[4] = (m_slot == 0);
         v[3] = (m_slot < IC0);
         v[2] = (m_slot >= 1) && (m_slot <= m_npix);
         v[1] = v[2];
         v[0] = (m_slot >= OUT_LAT + 1) && (m_slot <= m_npix + OUT_LAT);
      end
      return v;
   endfunction

   task automatic model_update(bit st, int np, bit sv);
      if (m_done_now) begin
         m_done_now = 0;
      end else if (m_in_tile) begin
         if (sv) begin
            if (m_slot == m_last) begin
               m_in_tile  = 0;
               m_done_now = 1;
            end else begin
               m_slot++;
            end
         end else if (m_stall < (1 << CNT_W) - 1) begin
            m_stall++;
         end
      end else if (st) begin
         m_stall = 0;
         if (np == 0) begin
            m_done_now = 1;
         end else begin
            m_in_tile = 1;
            m_slot    = 0;
            m_npix    = np;
            m_last    = np + OUT_LAT;
         end
      end
   endtask

   task automatic model_reset();
      m_in_tile  = 0;
      m_done_now = 0;
      m_slot     = 0;
      m_stall    = 0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, sample mid-cycle, compare, advance past the edge.
   task automatic step(input bit st, input int np, input bit sv, input string name,
                       input bit use_tbl, input logic [7:0] texp);
      start     = st;
      npix      = CNT_W'(np);
      src_valid = sv;
      #1;
      last_v = dut_vec();
      check(name, 32'(last_v), 32'(model_vec(sv)));
      if (use_tbl) check({name, "_tbl"}, 32'(last_v), 32'(texp));
`ifdef MAC_SEQ_PERF_EN
      last_stall = int'(stall_cnt);
      check({name, "_stall"}, 32'(stall_cnt), 32'(m_stall));
`else
      last_stall = 0;
`endif
      @(posedge clk);
      model_update(st, np, sv);
      #1;
   endtask

   task automatic run_until_done(input int budget, input string name, output int cyc);
      cyc = 0;
      for (int i = 0; i < budget; i++) begin
         step(1'b0, 0, 1'b1, name, 1'b0, 8'h00);
         cyc++;
         if (last_v[6]) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
   endtask

   typedef struct {
      bit         st;
      int         np;
      bit         sv;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int cyc;
      int n_if;
      int n_ao;
      int done_at;

      // Nominal npix=4 tile, hand-derived per cycle.
      tbl[0] = '{1'b1, 4, 1'b1, 8'b0000_0000};
      tbl[1] = '{1'b0, 0, 1'b1, 8'b1011_1000};
      tbl[2] = '{1'b0, 0, 1'b1, 8'b1010_1110};
      tbl[3] = '{1'b0, 0, 1'b1, 8'b1010_0110};
      tbl[4] = '{1'b0, 0, 1'b1, 8'b1010_0111};
      tbl[5] = '{1'b0, 0, 1'b1, 8'b1010_0111};
      tbl[6] = '{1'b0, 0, 1'b1, 8'b1010_0001};
      tbl[7] = '{1'b0, 0, 1'b1, 8'b1010_0001};
      tbl[8] = '{1'b0, 0, 1'b1, 8'b1100_0000};
      tbl[9] = '{1'b0, 0, 1'b1, 8'b0000_0000};

      // Reset state, with inputs that would otherwise start a tile.
      start = 1'b1; npix = CNT_W'(3); src_valid = 1'b1;
      #12;
      check("reset_outputs", 32'(dut_vec()), 32'h0);
      @(posedge clk); #1;
      check("reset_hold", 32'(dut_vec()), 32'h0);
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].st, tbl[i].np, tbl[i].sv, "nominal", 1'b1, tbl[i].exp);
      end

      // Stall for two cycles at k=2: gated outputs, done two cycles later.
      step(1'b1, 4, 1'b1, "stall", 1'b0, 8'h00);
      step(1'b0, 0, 1'b1, "stall", 1'b0, 8'h00);
      step(1'b0, 0, 1'b1, "stall", 1'b0, 8'h00);
      step(1'b0, 0, 1'b0, "stall", 1'b0, 8'h00);
      check("stall_gate0", 32'(last_v), 32'h80);
      step(1'b0, 0, 1'b0, "stall", 1'b0, 8'h00);
      check("stall_gate1", 32'(last_v), 32'h80);
      step(1'b0, 0, 1'b1, "stall", 1'b0, 8'h00);
      check("stall_resume_k2", 32'(last_v), 32'b1010_0110);
      run_until_done(20, "stall", cyc);
      check("stall_done_delay", 32'(cyc), 32'd5);
`ifdef MAC_SEQ_PERF_EN
      check("stall_cnt_at_done", 32'(last_stall), 32'd2);
`endif
      // Back-to-back tile: stall count restarts.
      step(1'b1, 2, 1'b1, "b2b", 1'b0, 8'h00);
      run_until_done(20, "b2b", cyc);
      check("b2b_len", 32'(cyc), 32'd6);
`ifdef MAC_SEQ_PERF_EN
      check("b2b_stall_cnt", 32'(last_stall), 32'd0);
`endif

      // npix = 0: immediate done, one busy cycle, no enq.
      step(1'b1, 0, 1'b1, "npix0", 1'b0, 8'h00);
      step(1'b0, 0, 1'b1, "npix0", 1'b0, 8'h00);
      check("npix0_done", 32'(last_v), 32'hC0);
      step(1'b0, 0, 1'b1, "npix0", 1'b0, 8'h00);
      check("npix0_after", 32'(last_v), 32'h00);

      // start with npix=9 during STREAM is ignored.
      step(1'b1, 4, 1'b1, "ign", 1'b0, 8'h00);
      step(1'b0, 0, 1'b1, "ign", 1'b0, 8'h00);
      step(1'b0, 0, 1'b1, "ign", 1'b0, 8'h00);
      step(1'b1, 9, 1'b1, "ign", 1'b0, 8'h00);
      run_until_done(30, "ign", cyc);
      check("ign_remaining_len", 32'(cyc), 32'd5);
      step(1'b0, 0, 1'b1, "ign", 1'b0, 8'h00);
      check("ign_idle_after", 32'(last_v), 32'h00);

      // Asynchronous reset at k=3, then a full clean tile.
      step(1'b1, 4, 1'b1, "rst", 1'b0, 8'h00);
      step(1'b0, 0, 1'b1, "rst", 1'b0, 8'h00);
      step(1'b0, 0, 1'b1, "rst", 1'b0, 8'h00);
      step(1'b0, 0, 1'b1, "rst", 1'b0, 8'h00);
      start = 1'b0; src_valid = 1'b1;
      #1;
      check("pre_rst_k3", 32'(dut_vec()), 32'b1010_0111);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst", 32'(dut_vec()), 32'h0);
`ifdef MAC_SEQ_PERF_EN
      check("async_rst_stall", 32'(stall_cnt), 32'h0);
`endif
      model_reset();
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      step(1'b0, 0, 1'b1, "post_rst_idle", 1'b0, 8'h00);
      check("post_rst_idle", 32'(last_v), 32'h00);
      step(1'b1, 4, 1'b1, "post_rst", 1'b0, 8'h00);
      run_until_done(20, "post_rst", cyc);
      check("post_rst_len", 32'(cyc), 32'd8);

      // Narrow counter: npix = 15 with CNT_W = 4 must not wrap.
      w_start = 1'b1; w_npix = 4'd15; w_sv = 1'b1;
      @(posedge clk); #1;
      w_start = 1'b0;
      n_if = 0; n_ao = 0; done_at = -1;
      for (int i = 0; i < 40; i++) begin
         if (w_iq) n_if++;
         if (w_aoq) n_ao++;
         if (w_done && done_at < 0) done_at = i;
         @(posedge clk); #1;
      end
      check("wide_ifmap_cnt", 32'(n_if), 32'd15);
      check("wide_aout_cnt", 32'(n_ao), 32'd15);
      check("wide_done_at", 32'(done_at), 32'd18);
      check("wide_idle", 32'(w_busy), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) == 0, int'($urandom_range(0, 6)),
              $urandom_range(0, 4) != 0, "rand", 1'b0, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 The block SHALL have parameter IC0, default 2, meaning MAC array height, which is also the number of weight rows loaded per tile.
REQ-002 The block SHALL have parameter OC0, default 2, meaning MAC array width (informational; used only in assertions).
REQ-003 The block SHALL have parameter OUT_LAT, default 2, meaning cycles from first ifmap enqueue to first accum_out enqueue.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the width of the pixel count and internal counter.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; one clock, all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, width 1: tile start request, sampled only in IDLE.
REQ-008 The block SHALL have port npix, input, width CNT_W: OX0*OY0 pixel count, captured on start acceptance.
REQ-009 The block SHALL have port src_valid, input, width 1: upstream data available; low means stall.
REQ-010 The block SHALL have port busy, output, width 1: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, width 1: one-cycle pulse at tile completion.
REQ-012 The block SHALL have outputs en, en_weight00, weight_fifo_enq, ifmap_fifo_enq, accum_in_fifo_enq and accum_out_fifo_enq, each 1 bit, driving the same-named MAC array inputs.

Function
REQ-013 The block SHALL implement states IDLE, WLOAD, STREAM, DRAIN and DONE.
REQ-014 IDLE to WLOAD SHALL occur on the edge sampling start=1 with npix>0; npix SHALL be latched and active index k cleared to 0.
REQ-015 start with npix==0 SHALL go IDLE to DONE (done pulse, no enq); start outside IDLE SHALL be ignored.
REQ-016 k SHALL increment only on non-stalled active cycles; active states are WLOAD, STREAM and DRAIN.
REQ-017 en_weight00 SHALL be 1 only at k=0.
REQ-018 weight_fifo_enq SHALL be 1 for k in [0, IC0-1], including k values reached in STREAM or DRAIN.
REQ-019 ifmap_fifo_enq and accum_in_fifo_enq SHALL be 1 for k in [1, npix].
REQ-020 accum_out_fifo_enq SHALL be 1 for k in [1+OUT_LAT, npix+OUT_LAT].
REQ-021 en SHALL be 1 for every non-stalled active cycle.
REQ-022 State transitions SHALL be: WLOAD to STREAM after k=0; STREAM to DRAIN after k=npix; DRAIN to DONE after k=npix+OUT_LAT; DONE to IDLE unconditionally after one cycle.
REQ-023 Stall, defined as src_valid=0 in an active state, SHALL force en and all enq outputs to 0 and hold k and state.
REQ-024 All outputs SHALL be Moore-decoded from state and k, with no combinational path from start or npix to any output; src_valid gating is the only input-to-output path.
REQ-025 The k compare SHALL use CNT_W+1 bits so that npix+OUT_LAT does not wrap at npix = 2^CNT_W - 1.

Reset
REQ-026 Asserting rst_n low SHALL, asynchronously, set state to IDLE and clear k, latched npix, busy, done and all enq/en outputs to 0, including mid-tile; no partial tile SHALL resume.

Configuration
REQ-027 With MAC_SEQ_PERF_EN defined, the block SHALL add output stall_cnt[CNT_W-1:0] counting stalled active cycles of the current tile, cleared on start acceptance and saturating at its maximum.
REQ-028 Without MAC_SEQ_PERF_EN, the port and counter SHALL NOT exist.

Structure
REQ-029 The state enum (mac_seq_state_t) and the default CNT_W SHALL be placed in package mac_seq_pkg.
REQ-030 The block SHALL be a single module with no sub-module.

Verification
REQ-031 IC0=2, OUT_LAT=2, npix=4, src_valid=1: weight_enq at k=0..1, en_weight00 at k=0, ifmap/accum_in enq at k=1..4, accum_out enq at k=3..6, done 8 cycles after start sampled; driving mac_more yields accum_out 31_47, 34_54, 37_61, 40_68.
REQ-032 Same run with src_valid=0 for 2 cycles at k=2: all enq and en 0 during those cycles; enq pattern resumes at k=2; done is delayed by exactly 2 cycles.
REQ-033 start with npix=0: done pulse on the next cycle, no enq ever high, busy high for one cycle.
REQ-034 start asserted during STREAM with npix=9: ignored; the tile finishes with the originally latched npix=4.
REQ-035 rst_n low at k=3: all outputs 0 immediately (asynchronously); after release, state is IDLE and a new start runs a full correct tile.
REQ-036 With MAC_SEQ_PERF_EN defined, the REQ-032 scenario SHALL give stall_cnt=2 at done; back-to-back tiles SHALL restart the count from 0.
